// File: rtl/simple_arbiter_select_wr_if.sv
// Token channels of the steering merge: two data producers, a control producer,
// and the two registered result channels toward the consumer.
interface simple_arbiter_select_wr_if #(
    parameter int F = 8
);
    logic [F:0] left_data;
    logic       left_back_stop;
    logic [F:0] right_data;
    logic       right_back_stop;
    logic [1:0] choose_right;
    logic       choose_right_back_stop;
    logic [F:0] out_data;
    logic       down_stop;
    logic [1:0] chose_right;
    logic       chose_right_down_stop;

    // Producer/consumer side: drives tokens and stalls, observes back-stops and results.
    modport master (
        output left_data, right_data, choose_right, down_stop, chose_right_down_stop,
        input  left_back_stop, right_back_stop, choose_right_back_stop, out_data, chose_right
    );

    // Merge side.
    modport slave (
        input  left_data, right_data, choose_right, down_stop, chose_right_down_stop,
        output left_back_stop, right_back_stop, choose_right_back_stop, out_data, chose_right
    );
endinterface

// File: rtl/simple_arbiter_select_wr.sv
// Steering merge: a control token picks the left or right data token, forwards it to
// out_data and reports the chosen side on chose_right; both outputs are registered slots.
module simple_arbiter_select_wr #(
    parameter int F = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    simple_arbiter_select_wr_if.slave    bus
);
    logic [F:0] out_data_q, out_data_d;
    logic [1:0] chose_right_q, chose_right_d;

    logic ctl_v, sel, lv, rv, sv;
    logic od_rdy, cr_rdy, fire;
    logic [F:0] sel_token;

    // Valid bits count only when exactly 1, so X/Z never triggers a transfer.
    always_comb begin
        ctl_v     = (bus.choose_right[1] === 1'b1);
        sel       = (bus.choose_right[0] === 1'b1);
        lv        = (bus.left_data[F] === 1'b1);
        rv        = (bus.right_data[F] === 1'b1);
        sv        = sel ? rv : lv;
        sel_token = sel ? bus.right_data : bus.left_data;
        od_rdy    = !out_data_q[F] || !bus.down_stop;
        cr_rdy    = !chose_right_q[1] || !bus.chose_right_down_stop;
        // Both slots must accept so a decision is never split across the outputs.
        fire      = rst_n && ctl_v && sv && od_rdy && cr_rdy;
    end

    always_comb begin
        bus.left_back_stop         = lv && !(fire && !sel);
        bus.right_back_stop        = rv && !(fire && sel);
        bus.choose_right_back_stop = ctl_v && !fire;
    end

    always_comb begin
        out_data_d    = out_data_q;
        chose_right_d = chose_right_q;
        if (fire) begin
            out_data_d    = sel_token;
            chose_right_d = {1'b1, sel};
        end else begin
            // Drained slots drop their valid bit but keep the payload.
            if (!bus.down_stop)             out_data_d[F]    = 1'b0;
            if (!bus.chose_right_down_stop) chose_right_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q    <= '0;
            chose_right_q <= '0;
        end else begin
            out_data_q    <= out_data_d;
            chose_right_q <= chose_right_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.chose_right = chose_right_q;
endmodule

// File: tb/tb_simple_arbiter_select_wr.sv
// Directed bench for the steering merge: reset, selection, stalls, back-to-back, async reset.
module tb_simple_arbiter_select_wr;
    logic clk;
    logic rst_n;
    int checks;
    int failures;

    simple_arbiter_select_wr_if #(.F(8)) bus ();

    simple_arbiter_select_wr #(.F(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctl, input logic [8:0] l, input logic [8:0] r,
                         input logic ds, input logic crds);
        bus.choose_right          = ctl;
        bus.left_data             = l;
        bus.right_data            = r;
        bus.down_stop             = ds;
        bus.chose_right_down_stop = crds;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b00, 9'h133, 9'h000, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.out_data !== 9'h000) begin
            failures++;
            $display("FAIL reset_out_data got=%h exp=%h", bus.out_data, 9'h000);
        end
        checks++;
        if (bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL reset_chose_right got=%b exp=%b", bus.chose_right, 2'b00);
        end
        checks++;
        if ({bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop} !== 3'b100) begin
            failures++;
            $display("FAIL reset_back_stops got=%b exp=%b",
                     {bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop}, 3'b100);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_ctl();
        drive(2'b00, 9'h133, 9'h000, 1'b0, 1'b0);
        checks++;
        if ({bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop} !== 3'b100) begin
            failures++;
            $display("FAIL noctl_back_stops got=%b exp=%b",
                     {bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop}, 3'b100);
        end
        tick();
        checks++;
        if (bus.out_data[8] !== 1'b0 || bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL noctl_outputs got=%h/%b exp=0xx/00", bus.out_data, bus.chose_right);
        end
    endtask

    task automatic test_select_right();
        drive(2'b11, 9'h000, 9'h1FF, 1'b0, 1'b0);
        checks++;
        if (bus.right_back_stop !== 1'b0 || bus.choose_right_back_stop !== 1'b0) begin
            failures++;
            $display("FAIL right_back_stops got=%b%b exp=00",
                     bus.right_back_stop, bus.choose_right_back_stop);
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h1FF || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL right_outputs got=%h/%b exp=1ff/11", bus.out_data, bus.chose_right);
        end
    endtask

    task automatic test_back_to_back();
        // Inputs of the previous test still held: another token must fire right away.
        checks++;
        if (bus.right_back_stop !== 1'b0 || bus.choose_right_back_stop !== 1'b0) begin
            failures++;
            $display("FAIL b2b_back_stops got=%b%b exp=00",
                     bus.right_back_stop, bus.choose_right_back_stop);
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h1FF || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL b2b_outputs got=%h/%b exp=1ff/11", bus.out_data, bus.chose_right);
        end
        drive(2'b00, 9'h000, 9'h000, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.out_data !== 9'h0FF || bus.chose_right !== 2'b01) begin
            failures++;
            $display("FAIL drain_hold_payload got=%h/%b exp=0ff/01", bus.out_data, bus.chose_right);
        end
    endtask

    task automatic test_selected_invalid();
        drive(2'b11, 9'h1A5, 9'h000, 1'b0, 1'b1);
        checks++;
        if ({bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop} !== 3'b101) begin
            failures++;
            $display("FAIL selinv_back_stops got=%b exp=%b",
                     {bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop}, 3'b101);
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h0FF || bus.chose_right !== 2'b01) begin
            failures++;
            $display("FAIL selinv_outputs got=%h/%b exp=0ff/01", bus.out_data, bus.chose_right);
        end
    endtask

    task automatic test_report_stall();
        drive(2'b11, 9'h000, 9'h1C3, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.out_data !== 9'h1C3 || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL prefill_outputs got=%h/%b exp=1c3/11", bus.out_data, bus.chose_right);
        end
        drive(2'b10, 9'h1A5, 9'h000, 1'b0, 1'b1);
        checks++;
        if ({bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop} !== 3'b101) begin
            failures++;
            $display("FAIL crstall_back_stops got=%b exp=%b",
                     {bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop}, 3'b101);
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h0C3 || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL crstall_outputs got=%h/%b exp=0c3/11", bus.out_data, bus.chose_right);
        end
        drive(2'b10, 9'h1A5, 9'h000, 1'b0, 1'b0);
        checks++;
        if ({bus.left_back_stop, bus.choose_right_back_stop} !== 2'b00) begin
            failures++;
            $display("FAIL release_back_stops got=%b exp=00",
                     {bus.left_back_stop, bus.choose_right_back_stop});
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h1A5 || bus.chose_right !== 2'b10) begin
            failures++;
            $display("FAIL release_outputs got=%h/%b exp=1a5/10", bus.out_data, bus.chose_right);
        end
        // Data consumer stalls while the report drains on its own.
        drive(2'b00, 9'h000, 9'h000, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.out_data !== 9'h1A5 || bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL indep_drain got=%h/%b exp=1a5/00", bus.out_data, bus.chose_right);
        end
        // Data slot still stalled: a new decision must not fire.
        drive(2'b11, 9'h000, 9'h1FF, 1'b1, 1'b0);
        checks++;
        if ({bus.right_back_stop, bus.choose_right_back_stop} !== 2'b11) begin
            failures++;
            $display("FAIL odstall_back_stops got=%b exp=11",
                     {bus.right_back_stop, bus.choose_right_back_stop});
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h1A5 || bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL odstall_outputs got=%h/%b exp=1a5/00", bus.out_data, bus.chose_right);
        end
    endtask

    task automatic test_async_reset();
        drive(2'b11, 9'h000, 9'h1FF, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.out_data !== 9'h1FF || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL prereset_outputs got=%h/%b exp=1ff/11", bus.out_data, bus.chose_right);
        end
        bus.down_stop = 1'b1;
        bus.chose_right_down_stop = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_data !== 9'h000 || bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h/%b exp=000/00", bus.out_data, bus.chose_right);
        end
        drive(2'b11, 9'h1A5, 9'h1FF, 1'b0, 1'b0);
        checks++;
        if ({bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop} !== 3'b111) begin
            failures++;
            $display("FAIL inreset_back_stops got=%b exp=111",
                     {bus.left_back_stop, bus.right_back_stop, bus.choose_right_back_stop});
        end
        tick();
        checks++;
        if (bus.out_data !== 9'h000 || bus.chose_right !== 2'b00) begin
            failures++;
            $display("FAIL inreset_hold got=%h/%b exp=000/00", bus.out_data, bus.chose_right);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_data !== 9'h1FF || bus.chose_right !== 2'b11) begin
            failures++;
            $display("FAIL postreset_fire got=%h/%b exp=1ff/11", bus.out_data, bus.chose_right);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_no_ctl();
        test_select_right();
        test_back_to_back();
        test_selected_invalid();
        test_report_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
